// File: rtl/spram_check_pkg.sv
// Shared constants and state encoding for the SPRAM read-back checker
// and its companion pattern writer.
package spram_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Galois taps for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/lfsr16_step.sv
// One step of the 16-bit Galois LFSR; shared with the pattern writer so
// both sides walk the identical sequence.
module lfsr16_step
    import spram_check_pkg::*;
(
    input  logic [15:0] cur,
    output logic [15:0] nxt
);

    assign nxt = (cur >> 1) ^ (cur[0] ? LFSR_POLY : 16'h0000);

endmodule

// File: rtl/spram_checker.sv
// Reads every SPRAM word through a 1-cycle-latency port and compares it
// against the LFSR pattern; reports running/passed plus first-error info.
module spram_checker
    import spram_check_pkg::*;
#(
    parameter int                 ADDR_SZ = 14,
    parameter int                 DATA_SZ = 16,
    parameter logic [DATA_SZ-1:0] SEED    = 16'hACE1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    output logic                 o_rd_en,
    output logic [ADDR_SZ-1:0]   o_raddr,
    input  logic [DATA_SZ-1:0]   i_rdata,
    output logic                 o_running,
    output logic                 o_done,
    output logic                 o_passed,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic [ADDR_SZ-1:0]   o_err_addr,
    output logic [DATA_SZ-1:0]   o_err_data
);

    localparam logic [ADDR_SZ-1:0] ADDR_LAST = '1;

    state_t                 state;
    logic                   run_q;
    // [0]: read issued this cycle, [1]: its data is on i_rdata now
    logic [1:0]             vld_pipe;
    logic [ADDR_SZ-1:0]     addr, cmp_addr;
    logic [DATA_SZ-1:0]     exp_q, exp_nxt, cmp_exp;
    logic                   running_q, done_q, passed_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_nxt;
    logic [ADDR_SZ-1:0]     err_addr_q;
    logic [DATA_SZ-1:0]     err_data_q;
    logic                   run_edge, start, mism;

    lfsr16_step u_step (.cur(exp_q), .nxt(exp_nxt));

    assign run_edge    = i_run && !run_q;
    assign start       = run_edge && (state == ST_IDLE || state == ST_DONE);
    assign mism        = vld_pipe[1] && (i_rdata != cmp_exp);
    assign err_cnt_nxt = (mism && err_cnt_q != ERR_CNT_MAX) ? err_cnt_q + 1'b1 : err_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            run_q      <= 1'b0;
            vld_pipe   <= '0;
            addr       <= '0;
            cmp_addr   <= '0;
            exp_q      <= '0;
            cmp_exp    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            passed_q   <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            run_q       <= i_run;
            vld_pipe[1] <= vld_pipe[0];

            if (mism) begin
                err_cnt_q <= err_cnt_nxt;
                if (err_cnt_q == '0) begin
                    err_addr_q <= cmp_addr;
                    err_data_q <= i_rdata;
                end
            end

            case (state)
                ST_READ: begin
                    exp_q    <= exp_nxt;
                    cmp_exp  <= exp_q;
                    cmp_addr <= addr;
                    // address holds at the last word through DRAIN and DONE
                    if (addr == ADDR_LAST) begin
                        state       <= ST_DRAIN;
                        vld_pipe[0] <= 1'b0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_DONE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                    passed_q  <= (err_cnt_nxt == '0);
                end
                default: ;
            endcase

            if (start) begin
                state       <= ST_READ;
                vld_pipe[0] <= 1'b1;
                addr        <= '0;
                exp_q       <= SEED;
                running_q   <= 1'b1;
                done_q      <= 1'b0;
                passed_q    <= 1'b0;
                err_cnt_q   <= '0;
                err_addr_q  <= '0;
                err_data_q  <= '0;
            end
        end
    end

    assign o_rd_en    = vld_pipe[0];
    assign o_raddr    = addr;
    assign o_running  = running_q;
    assign o_done     = done_q;
    assign o_passed   = passed_q;
    assign o_err_cnt  = err_cnt_q;
    assign o_err_addr = err_addr_q;
    assign o_err_data = err_data_q;

endmodule

// File: tb/tb_spram_checker.sv
// Bench for spram_checker: 16-word, 512-word and zero-seed instances,
// each with a 1-cycle-latency memory model.
module tb_spram_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // ---------------- instance A: ADDR_SZ=4, default seed
    logic        run_a, rd_en_a, running_a, done_a, passed_a;
    logic [3:0]  raddr_a, err_addr_a;
    logic [15:0] rdata_a, err_data_a;
    logic [7:0]  err_cnt_a;
    logic [15:0] mem_a [16];

    spram_checker #(.ADDR_SZ(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run_a),
        .o_rd_en(rd_en_a), .o_raddr(raddr_a), .i_rdata(rdata_a),
        .o_running(running_a), .o_done(done_a), .o_passed(passed_a),
        .o_err_cnt(err_cnt_a), .o_err_addr(err_addr_a), .o_err_data(err_data_a)
    );
    always @(posedge clk) if (rd_en_a) rdata_a <= mem_a[raddr_a];

    // ---------------- instance B: ADDR_SZ=9, memory all zeros
    logic        run_b, rd_en_b, running_b, done_b, passed_b;
    logic [8:0]  raddr_b, err_addr_b;
    logic [15:0] rdata_b, err_data_b;
    logic [7:0]  err_cnt_b;
    logic [15:0] mem_b [512];

    spram_checker #(.ADDR_SZ(9)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run_b),
        .o_rd_en(rd_en_b), .o_raddr(raddr_b), .i_rdata(rdata_b),
        .o_running(running_b), .o_done(done_b), .o_passed(passed_b),
        .o_err_cnt(err_cnt_b), .o_err_addr(err_addr_b), .o_err_data(err_data_b)
    );
    always @(posedge clk) if (rd_en_b) rdata_b <= mem_b[raddr_b];

    // ---------------- instance C: ADDR_SZ=3, SEED=0, memory all zeros
    logic        run_c, rd_en_c, running_c, done_c, passed_c;
    logic [2:0]  raddr_c, err_addr_c;
    logic [15:0] rdata_c, err_data_c;
    logic [7:0]  err_cnt_c;
    logic [15:0] mem_c [8];

    spram_checker #(.ADDR_SZ(3), .SEED(16'h0000)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run_c),
        .o_rd_en(rd_en_c), .o_raddr(raddr_c), .i_rdata(rdata_c),
        .o_running(running_c), .o_done(done_c), .o_passed(passed_c),
        .o_err_cnt(err_cnt_c), .o_err_addr(err_addr_c), .o_err_data(err_data_c)
    );
    always @(posedge clk) if (rd_en_c) rdata_c <= mem_c[raddr_c];

    // ---------------- address scoreboard for instance A
    logic [3:0] q_addr [$];
    logic [3:0] mon_e;
    always @(negedge clk) begin
        if (rd_en_a) begin
            if (q_addr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL raddr_unexpected: got %0h with no read expected", raddr_a);
            end else begin
                mon_e = q_addr.pop_front();
                chk("raddr", 32'(raddr_a), 32'(mon_e));
            end
        end
    end

    task automatic push_addrs();
        for (int i = 0; i < 16; i++) q_addr.push_back(4'(i));
    endtask

    task automatic fill_a();
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = v;
            v = lfsr_nx(v);
        end
        mem_a[0] = 16'hACE1;
        mem_a[1] = 16'hE270;
        mem_a[2] = 16'h7138;
        mem_a[3] = 16'h389C;
    endtask

    // pulse i_run on A, measure running length; optional extra edge mid-READ
    task automatic do_run_a(input bit tog, output int cyc);
        push_addrs();
        @(negedge clk) run_a = 1'b1;
        @(negedge clk) run_a = 1'b0;
        chk("start_done_clr", 32'(done_a), 32'd0);
        chk("start_err_clr", 32'(err_cnt_a), 32'd0);
        cyc = 0;
        while (running_a && cyc < 100) begin
            cyc++;
            if (tog && cyc == 6) run_a = 1'b1;
            if (tog && cyc == 9) run_a = 1'b0;
            @(negedge clk);
        end
        chk("addr_q_drained", 32'(q_addr.size()), 32'd0);
    endtask

    typedef struct {
        string       name;
        int          a1;
        logic [15:0] v1;
        int          a2;
        logic [15:0] v2;
        bit          tog;
        int          e_cnt;
        int          e_addr;
        logic [15:0] e_data;
        bit          e_pass;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc;
        int n_run;
        vecs[0] = '{"pass",      -1, 16'h0000, -1, 16'h0000, 1'b0, 0,  0, 16'h0000, 1'b1};
        vecs[1] = '{"two_err",    5, 16'h0000,  9, 16'h0000, 1'b0, 2,  5, 16'h0000, 1'b0};
        vecs[2] = '{"seed_a2",    2, 16'h7139, -1, 16'h0000, 1'b0, 1,  2, 16'h7139, 1'b0};
        vecs[3] = '{"toggle",    -1, 16'h0000, -1, 16'h0000, 1'b1, 0,  0, 16'h0000, 1'b1};
        vecs[4] = '{"last_word", 15, 16'h0000, -1, 16'h0000, 1'b0, 1, 15, 16'h0000, 1'b0};
        vecs[5] = '{"first_wd",   0, 16'h0000, -1, 16'h0000, 1'b0, 1,  0, 16'h0000, 1'b0};

        rst_n = 1'b0;
        run_a = 1'b0;
        run_b = 1'b0;
        run_c = 1'b0;
        fill_a();
        for (int i = 0; i < 512; i++) mem_b[i] = 16'h0000;
        for (int i = 0; i < 8; i++) mem_c[i] = 16'h0000;

        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({rd_en_a, running_a, done_a, passed_a}), 32'd0);
        chk("rst_addr", 32'(raddr_a), 32'd0);
        chk("rst_err", 32'({err_cnt_a, err_addr_a, err_data_a}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_run", 32'({rd_en_a, running_a}), 32'd0);

        for (int k = 0; k < 6; k++) begin
            fill_a();
            if (vecs[k].a1 >= 0) mem_a[vecs[k].a1] = vecs[k].v1;
            if (vecs[k].a2 >= 0) mem_a[vecs[k].a2] = vecs[k].v2;
            do_run_a(vecs[k].tog, cyc);
            chk({vecs[k].name, "_len"}, 32'(cyc), 32'd17);
            chk({vecs[k].name, "_done"}, 32'(done_a), 32'd1);
            chk({vecs[k].name, "_passed"}, 32'(passed_a), 32'(vecs[k].e_pass));
            chk({vecs[k].name, "_cnt"}, 32'(err_cnt_a), 32'(vecs[k].e_cnt));
            chk({vecs[k].name, "_eaddr"}, 32'(err_addr_a), 32'(vecs[k].e_addr));
            chk({vecs[k].name, "_edata"}, 32'(err_data_a), 32'(vecs[k].e_data));
            chk({vecs[k].name, "_raddr_hold"}, 32'(raddr_a), 32'd15);
        end

        // reset mid-run: outputs clear asynchronously, then stay idle
        fill_a();
        mem_a[1] = 16'h0000;
        push_addrs();
        @(negedge clk) run_a = 1'b1;
        @(negedge clk) run_a = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_err_seen", 32'(err_cnt_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({rd_en_a, running_a, done_a, passed_a}), 32'd0);
        chk("mid_rst_addr", 32'(raddr_a), 32'd0);
        chk("mid_rst_err", 32'({err_cnt_a, err_addr_a, err_data_a}), 32'd0);
        q_addr.delete();
        @(negedge clk) rst_n = 1'b1;
        n_run = 0;
        repeat (6) begin
            @(negedge clk);
            if (running_a || rd_en_a || done_a) n_run++;
        end
        chk("post_rst_idle", 32'(n_run), 32'd0);

        // i_run high through reset release: exactly one run
        fill_a();
        @(negedge clk) begin
            rst_n = 1'b0;
            run_a = 1'b1;
        end
        push_addrs();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (running_a && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("held_len", 32'(cyc), 32'd17);
        chk("held_passed", 32'(passed_a), 32'd1);
        n_run = 0;
        repeat (20) begin
            @(negedge clk);
            if (running_a || !done_a) n_run++;
        end
        chk("held_no_restart", 32'(n_run), 32'd0);
        run_a = 1'b0;

        // saturation on the 512-word instance
        @(negedge clk) run_b = 1'b1;
        @(negedge clk) run_b = 1'b0;
        cyc = 0;
        while (running_b && cyc < 700) begin
            cyc++;
            @(negedge clk);
        end
        chk("sat_len", 32'(cyc), 32'd513);
        chk("sat_done", 32'(done_b), 32'd1);
        chk("sat_cnt", 32'(err_cnt_b), 32'd255);
        chk("sat_eaddr", 32'(err_addr_b), 32'd0);
        chk("sat_edata", 32'(err_data_b), 32'd0);
        chk("sat_passed", 32'(passed_b), 32'd0);

        // zero seed: all-zero memory passes
        @(negedge clk) run_c = 1'b1;
        @(negedge clk) run_c = 1'b0;
        cyc = 0;
        while (running_c && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("seed0_len", 32'(cyc), 32'd9);
        chk("seed0_passed", 32'({done_c, passed_c}), 32'd3);
        chk("seed0_cnt", 32'(err_cnt_c), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
